irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_ctrl_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 119 +++++++++++
 tb/tb_irq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// default vector base and the line-index width helper.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam logic [9:0] VEC_BASE_DEFAULT = 10'h3F0;

  // A single line still needs a 1-bit index so port widths never collapse to zero.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
// Purely combinational.
module prio_enc
  import irq_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  i_req,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: edge-latched requests, fixed lowest-index priority,
// non-nesting request/acknowledge/return handshake with the control unit.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int              NIRQ     = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  input  logic            ien_in,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_req,
  output logic [PC_W-1:0] int_vec,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] in_service
);

  localparam int IW = id_w(NIRQ);

  state_t          r_state;
  state_t          w_next;
  logic [NIRQ-1:0] r_irq_q;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_mask;
  logic            r_ien;
  logic [IW-1:0]   r_cur_id;

  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_elig;
  logic [NIRQ-1:0] w_cur_oh;
  logic [NIRQ-1:0] w_clr;
  logic            w_win_vld;
  logic [IW-1:0]   w_win_idx;
  logic            w_latch;

  assign w_rise   = irq & ~r_irq_q;
  assign w_elig   = {NIRQ{r_ien}} & r_pending & r_mask;
  assign w_cur_oh = NIRQ'(1) << r_cur_id;
  assign pending  = r_pending;

  prio_enc #(
    .N  (NIRQ),
    .IW (IW)
  ) u_prio_enc (
    .i_req (w_elig),
    .o_vld (w_win_vld),
    .o_idx (w_win_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_win_vld) w_next = REQ;
      end
      REQ: begin
        // Withdraw uses the registered mask/enable, so a mask write lands one cycle later.
        if (int_ack)                         w_next = SERVE;
        else if (!r_mask[r_cur_id] || !r_ien) w_next = IDLE;
      end
      SERVE: begin
        if (reti) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    int_req    = 1'b0;
    int_vec    = '0;
    in_service = '0;
    w_clr      = '0;
    w_latch    = 1'b0;
    case (r_state)
      IDLE: begin
        w_latch = w_win_vld;
      end
      REQ: begin
        int_req = 1'b1;
        int_vec = VEC_BASE + PC_W'({r_cur_id, 2'b00});
        if (int_ack) w_clr = w_cur_oh;
      end
      SERVE: begin
        in_service = w_cur_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // Tracks irq through reset so a line held high across release is not an edge.
    r_irq_q <= irq;
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_ien     <= 1'b0;
      r_cur_id  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_in;
        r_ien  <= ien_in;
      end
      if (w_latch) r_cur_id <= w_win_idx;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a line-level reference model.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ien_in;
  logic       int_ack;
  logic       reti;
  logic       int_req;
  logic [9:0] int_vec;
  logic [3:0] pending;
  logic [3:0] in_service;

  always #5 clk = ~clk;

  irq_ctrl #(
    .NIRQ     (4),
    .PC_W     (10),
    .VEC_BASE (10'h3F0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .ien_in     (ien_in),
    .int_ack    (int_ack),
    .reti       (reti),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: which line is requested / in service (-1 = none), plus latched events.
  int         m_req;
  int         m_srv;
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic       m_ien;
  logic [3:0] m_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] elig;
    int nreq;
    int nsrv;
    if (reset) begin
      m_req = -1; m_srv = -1; m_pend = '0; m_mask = '0; m_ien = 1'b0; m_prev = irq;
      return;
    end
    rise   = irq & ~m_prev;
    m_prev = irq;
    nreq   = m_req;
    nsrv   = m_srv;
    if (m_req >= 0) begin
      if (int_ack) begin
        m_pend[m_req] = 1'b0;
        nsrv = m_req;
        nreq = -1;
      end else if (!m_mask[m_req] || !m_ien) begin
        nreq = -1;
      end
    end else if (m_srv >= 0) begin
      if (reti) nsrv = -1;
    end else begin
      elig = m_ien ? (m_pend & m_mask) : 4'b0000;
      for (int i = 3; i >= 0; i--) if (elig[i]) nreq = i;
    end
    m_pend = m_pend | rise;
    if (mask_we) begin
      m_mask = mask_in;
      m_ien  = ien_in;
    end
    m_req = nreq;
    m_srv = nsrv;
  endtask

  task automatic compare_all();
    logic [31:0] exp_vec;
    logic [31:0] exp_srv;
    exp_vec = (m_req >= 0) ? ((32'h3F0 + 32'(4 * m_req)) & 32'h3FF) : 32'h0;
    exp_srv = (m_srv >= 0) ? (32'd1 << m_srv) : 32'h0;
    check_eq("int_req",    {31'b0, int_req},   {31'b0, (m_req >= 0)});
    check_eq("int_vec",    {22'b0, int_vec},   exp_vec);
    check_eq("pending",    {28'b0, pending},   {28'b0, m_pend});
    check_eq("in_service", {28'b0, in_service}, exp_srv);
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare just after.
  task automatic step(input logic [3:0] iq, input logic ack = 1'b0, input logic rt = 1'b0,
                      input logic we = 1'b0, input logic [3:0] mk = 4'b0000,
                      input logic ie = 1'b0, input logic rst = 1'b0);
    irq = iq; int_ack = ack; reti = rt; mask_we = we; mask_in = mk; ien_in = ie; reset = rst;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] nx;
    logic [3:0] cur;

    irq = '0; int_ack = 0; reti = 0; mask_we = 0; mask_in = '0; ien_in = 0; reset = 1;
    m_req = -1; m_srv = -1; m_pend = '0; m_mask = '0; m_ien = 0; m_prev = '0;
    #2;

    // Reset state
    step(4'b0000, 0, 0, 0, 4'b0000, 0, 1);
    step(4'b0000, 0, 0, 0, 4'b0000, 0, 1);
    check_eq("rst_int_req", {31'b0, int_req}, 32'd0);
    check_eq("rst_pending", {28'b0, pending}, 32'd0);

    // Single line: rise on irq[2], request two edges later, ack moves it into service
    step(4'b0000, 0, 0, 1, 4'b1111, 1);
    step(4'b0100);
    check_eq("l2_pending", {28'b0, pending}, 32'h4);
    check_eq("l2_no_req_yet", {31'b0, int_req}, 32'd0);
    step(4'b0100);
    check_eq("l2_req", {31'b0, int_req}, 32'd1);
    check_eq("l2_vec", {22'b0, int_vec}, 32'h3F8);
    step(4'b0100, 1);
    check_eq("l2_in_service", {28'b0, in_service}, 32'h4);
    check_eq("l2_pend_clr", {28'b0, pending}, 32'h0);
    step(4'b0000, 0, 1);
    step(4'b0000);

    // Simultaneous rises: lowest index first, the other follows the return
    step(4'b1010);
    step(4'b1010);
    check_eq("l1_vec", {22'b0, int_vec}, 32'h3F4);
    step(4'b1010, 1);
    step(4'b1010, 0, 1);
    step(4'b1010);
    check_eq("l3_req_after_reti", {31'b0, int_req}, 32'd1);
    check_eq("l3_vec", {22'b0, int_vec}, 32'h3FC);
    step(4'b0000, 1);
    step(4'b0000, 0, 1);

    // No nesting: a new event during service only accumulates
    step(4'b0100);
    step(4'b0100);
    step(4'b0100, 1);
    step(4'b0101);
    check_eq("nest_pending", {28'b0, pending}, 32'h1);
    check_eq("nest_no_req", {31'b0, int_req}, 32'd0);
    step(4'b0101);
    step(4'b0101, 0, 1);
    step(4'b0101);
    check_eq("nest_l0_vec", {22'b0, int_vec}, 32'h3F0);
    step(4'b0000, 1);
    step(4'b0000, 0, 1);

    // Withdraw: masking the requested line drops the request, event stays latched
    step(4'b0010);
    step(4'b0010);
    step(4'b0010, 0, 0, 1, 4'b1101, 1);
    step(4'b0010);
    check_eq("wd_int_req", {31'b0, int_req}, 32'd0);
    check_eq("wd_pending", {28'b0, pending}, 32'h2);
    step(4'b0010);

    // Line held high through reset produces no event until it re-rises
    step(4'b0001, 0, 0, 0, 4'b0000, 0, 1);
    step(4'b0001, 0, 0, 1, 4'b0001, 1);
    step(4'b0001);
    step(4'b0001);
    check_eq("held_no_req", {31'b0, int_req}, 32'd0);
    step(4'b0000);
    step(4'b0001);
    step(4'b0001);
    check_eq("held_rerise_req", {31'b0, int_req}, 32'd1);

    // Reset during service abandons it; later strobes are ignored
    step(4'b0001, 1);
    step(4'b0001, 0, 0, 0, 4'b0000, 0, 1);
    check_eq("rst_srv_in_service", {28'b0, in_service}, 32'd0);
    step(4'b0001, 1, 1);
    step(4'b0001, 1, 1);
    check_eq("rst_srv_no_req", {31'b0, int_req}, 32'd0);

    // Random traffic
    cur = 4'b0001;
    for (int n = 0; n < 3000; n++) begin
      nx = cur;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) nx[b] = ~nx[b];
      cur = nx;
      step(cur,
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0 || n == 0),
           4'($urandom),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
